// File: rtl/nor_gate_sweeper_pkg.sv
// Shared types and helpers for the NOR gate sweeper BIST.
// Step encoding: {mask[1:0], in2, in1}.
package nor_gate_sweeper_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam int STEP_W    = 4;
  localparam int NUM_STEPS = 16;

  function automatic logic exp_bit(
    input logic [STEP_W-1:0] s
  );
    return ~((s[0] ^ s[2]) | (s[1] ^ s[3]));
  endfunction

endpackage

// File: rtl/nor_gate_sweeper_settle_timer.sv
// Loadable down-counter with zero flag.
// Holds at zero; reload value is MAX.
module settle_timer #(
  parameter int MAX = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= W'(MAX);
    end else if (i_dec && r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/nor_gate_sweeper.sv
// BIST sweeper: drives a bubbled NOR gate through 16 steps
// and scores the sampled outputs against the ideal table.
module nor_gate_sweeper
  import nor_gate_sweeper_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic        gate_result,
  output logic        gate_in1,
  output logic        gate_in2,
  output logic [1:0]  gate_mask,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  mismatch_count,
  output logic [15:0] result_vector
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [STEP_W-1:0]   r_step;
  logic [STEP_W-1:0]   w_step_nxt;
  logic                w_load;
  logic                w_dec;
  logic                w_zero;
  logic                w_clear;
  logic                w_sample;
  logic                w_last;
  logic                w_miss;
  logic                w_drive;
  logic [4:0]          w_mm_nxt;

  settle_timer #(
    .MAX(SETTLE_CYCLES)
  ) u_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .i_load (w_load),
    .i_dec  (w_dec),
    .o_zero (w_zero)
  );

  assign w_last   = (r_step == STEP_W'(NUM_STEPS - 1));
  assign w_miss   = (gate_result != exp_bit(r_step));
  assign w_mm_nxt = mismatch_count + 5'(w_miss);

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    w_clear     = 1'b0;
    w_sample    = 1'b0;
    unique case (1'b1)
      (r_state == IDLE): begin
        if (start && !abort) begin
          w_state_nxt = SETTLE;
          w_step_nxt  = '0;
          w_load      = 1'b1;
          w_clear     = 1'b1;
        end
      end
      (r_state == SETTLE): begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (w_zero) begin
          w_state_nxt = SAMPLE;
        end else begin
          w_dec = 1'b1;
        end
      end
      (r_state == SAMPLE): begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else begin
          w_sample = 1'b1;
          if (w_last) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = SETTLE;
            w_step_nxt  = r_step + STEP_W'(1);
            w_load      = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_step  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
    end
  end

  // Gate drive is registered from the next step so it is valid
  // in the very cycle the step begins.
  assign w_drive = (w_state_nxt == SETTLE) || (w_state_nxt == SAMPLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gate_in1  <= 1'b0;
      gate_in2  <= 1'b0;
      gate_mask <= 2'b00;
    end else begin
      gate_in1  <= w_drive & w_step_nxt[0];
      gate_in2  <= w_drive & w_step_nxt[1];
      gate_mask <= w_drive ? w_step_nxt[3:2] : 2'b00;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      result_vector  <= '0;
      mismatch_count <= '0;
      pass           <= 1'b0;
    end else if (w_clear) begin
      result_vector  <= '0;
      mismatch_count <= '0;
      pass           <= 1'b0;
    end else if (w_sample) begin
      result_vector[r_step] <= gate_result;
      mismatch_count        <= w_mm_nxt;
      if (w_last) begin
        pass <= (w_mm_nxt == 5'd0);
      end
    end
  end

  assign busy = (r_state == SETTLE) || (r_state == SAMPLE);
  assign done = (r_state == DONE);

endmodule

// File: tb/tb_nor_gate_sweeper.sv
// Bench for nor_gate_sweeper: table of gate models run on
// S=1 and S=0 instances, plus abort and reset sequences.
module tb_nor_gate_sweeper;

  typedef struct {
    int          mode;
    int          sel;
    logic [15:0] rv;
    logic [4:0]  mm;
    logic        ps;
  } vec_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n;
  logic st;
  logic abort;
  int   sel;
  int   mode;
  int   total = 0;
  int   bad   = 0;

  logic        a_start, a_gr, a_in1, a_in2, a_busy, a_done, a_pass;
  logic [1:0]  a_mask;
  logic [4:0]  a_mm;
  logic [15:0] a_rv;
  logic        b_start, b_gr, b_in1, b_in2, b_busy, b_done, b_pass;
  logic [1:0]  b_mask;
  logic [4:0]  b_mm;
  logic [15:0] b_rv;

  logic        o_busy, o_done, o_pass;
  logic [3:0]  o_gate;
  logic [4:0]  o_mm;
  logic [15:0] o_rv;

  function automatic logic gate_model(
    input int m, input logic i1, input logic i2, input logic [1:0] k
  );
    logic x1, x2;
    x1 = i1 ^ k[0];
    x2 = i2 ^ k[1];
    case (m)
      0:       return ~(x1 | x2);
      1:       return 1'b0;
      2:       return 1'b1;
      default: return x1 | x2;
    endcase
  endfunction

  assign a_start = st && (sel == 1);
  assign b_start = st && (sel == 0);
  assign a_gr    = gate_model(mode, a_in1, a_in2, a_mask);
  assign b_gr    = gate_model(mode, b_in1, b_in2, b_mask);

  assign o_busy = (sel == 1) ? a_busy : b_busy;
  assign o_done = (sel == 1) ? a_done : b_done;
  assign o_pass = (sel == 1) ? a_pass : b_pass;
  assign o_mm   = (sel == 1) ? a_mm : b_mm;
  assign o_rv   = (sel == 1) ? a_rv : b_rv;
  assign o_gate = (sel == 1) ? {a_mask, a_in2, a_in1}
                             : {b_mask, b_in2, b_in1};

  nor_gate_sweeper #(.SETTLE_CYCLES(1)) u_dut_s1 (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (a_start),
    .abort         (abort),
    .gate_result   (a_gr),
    .gate_in1      (a_in1),
    .gate_in2      (a_in2),
    .gate_mask     (a_mask),
    .busy          (a_busy),
    .done          (a_done),
    .pass          (a_pass),
    .mismatch_count(a_mm),
    .result_vector (a_rv)
  );

  nor_gate_sweeper #(.SETTLE_CYCLES(0)) u_dut_s0 (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (b_start),
    .abort         (abort),
    .gate_result   (b_gr),
    .gate_in1      (b_in1),
    .gate_in2      (b_in2),
    .gate_mask     (b_mask),
    .busy          (b_busy),
    .done          (b_done),
    .pass          (b_pass),
    .mismatch_count(b_mm),
    .result_vector (b_rv)
  );

  vec_t tbl [5];
  vec_t sb  [$];

  task automatic check(
    input string name, input logic [31:0] act, input logic [31:0] req
  );
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int   per;
    int   c;
    logic busy_ok;
    logic gate_ok;
    vec_t e;
    mode = v.mode;
    sel  = v.sel;
    per  = (v.sel == 1) ? 3 : 2;
    st   = 1'b1;
    sb.push_back(v);
    tick();
    st      = 1'b0;
    c       = 0;
    busy_ok = 1'b1;
    gate_ok = 1'b1;
    while (!o_done && c < 200) begin
      if (!o_busy) busy_ok = 1'b0;
      if (o_gate != 4'(c / per)) gate_ok = 1'b0;
      tick();
      c++;
    end
    check("done_latency", c, 16 * per);
    check("busy_during_sweep", 32'(busy_ok), 1);
    check("gate_step_order", 32'(gate_ok), 1);
    check("busy_in_done", 32'(o_busy), 0);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      check("result_vector", 32'(o_rv), 32'(e.rv));
      check("mismatch_count", 32'(o_mm), 32'(e.mm));
      check("pass", 32'(o_pass), 32'(e.ps));
      tick();
      check("done_one_cycle", 32'(o_done), 0);
      check("rv_held", 32'(o_rv), 32'(e.rv));
      check("pass_held", 32'(o_pass), 32'(e.ps));
    end
  endtask

  initial begin
    int   c;
    logic seen;
    tbl[0] = '{mode: 0, sel: 1, rv: 16'h8421, mm: 5'd0,  ps: 1'b1};
    tbl[1] = '{mode: 1, sel: 1, rv: 16'h0000, mm: 5'd4,  ps: 1'b0};
    tbl[2] = '{mode: 2, sel: 1, rv: 16'hFFFF, mm: 5'd12, ps: 1'b0};
    tbl[3] = '{mode: 3, sel: 1, rv: 16'h7BDE, mm: 5'd16, ps: 1'b0};
    tbl[4] = '{mode: 0, sel: 0, rv: 16'h8421, mm: 5'd0,  ps: 1'b1};

    reset_n = 1'b0;
    st      = 1'b0;
    abort   = 1'b0;
    sel     = 1;
    mode    = 0;
    #1;
    check("reset_a_outputs",
          32'({a_busy, a_done, a_pass, a_mm, a_rv, a_in1, a_in2, a_mask}), 0);
    check("reset_b_outputs",
          32'({b_busy, b_done, b_pass, b_mm, b_rv, b_in1, b_in2, b_mask}), 0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      run_vec(tbl[i]);
    end

    // start while busy, then abort in step 7 SETTLE
    sel  = 1;
    mode = 0;
    st   = 1'b1;
    tick();
    st = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    st = 1'b1;
    tick();
    st = 1'b0;
    check("start_while_busy_ignored", 32'(o_gate), 3);
    for (int i = 11; i < 21; i++) tick();
    check("step7_reached", 32'(o_gate), 7);
    check("step7_settle_busy", 32'(o_busy), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(o_busy), 0);
    check("abort_gate", 32'(o_gate), 0);
    check("abort_rv_partial", 32'(o_rv), 32'h0021);
    check("abort_mm", 32'(o_mm), 0);
    check("abort_pass", 32'(o_pass), 0);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (o_done || o_busy) seen = 1'b1;
      tick();
    end
    check("abort_no_done", 32'(seen), 0);

    st    = 1'b1;
    abort = 1'b1;
    tick();
    tick();
    st    = 1'b0;
    abort = 1'b0;
    check("start_abort_idle_busy", 32'(o_busy), 0);
    check("start_abort_idle_rv", 32'(o_rv), 32'h0021);

    // asynchronous reset mid-sweep on the S=0 instance
    sel  = 0;
    mode = 3;
    st   = 1'b1;
    tick();
    st = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check("pre_reset_mm", 32'(o_mm), 6);
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_mid_busy", 32'(o_busy), 0);
    check("reset_mid_gate", 32'(o_gate), 0);
    check("reset_mid_rv", 32'(o_rv), 0);
    check("reset_mid_mm", 32'(o_mm), 0);
    check("reset_mid_done_pass", 32'({o_done, o_pass}), 0);
    tick();
    reset_n = 1'b1;
    tick();
    run_vec(tbl[4]);

    c = sb.size();
    check("scoreboard_drained", c, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
